fft_frame_receiver: RTL
=======================

# fft_frame_receiver

Receives the serial sample stream that the DFT sample buffer emits toward the FFT engine. It collects exactly N floating-point samples per frame into local memory at bit-reversed addresses, which is the input ordering the in-place radix-2 FFT core expects. It then holds the frame for random-access reads by the FFT core until the core releases it. The block sits between the sample buffer's unload port and the FFT engine's operand-fetch port.

## Interface
- N, 1024: samples per frame; must be a power of two, ≥ 4.
- fp_width, 32: sample width (IEEE-754 single).
- addr_width, 10: log2(N).

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  marks the first sample of a frame; qualified by sample_valid.
- sample_valid  in  1  data_in carries a sample this cycle.
- data_in  in  fp_width  sample value.
- frame_ready  out  1  complete frame held; read port is live.
- busy  out  1  high while filling a frame.
- fill_count  out  addr_width+1  samples accepted in the current frame, 0..N.
- rd_en  in  1  read request from the FFT core.
- rd_addr  in  addr_width  read address (natural FFT order).
- rd_data  out  fp_width  registered read data.
- frame_release  in  1  FFT core is done with the frame.
- overrun  out  1  sticky error flag.

## Operation
- Storage: N × fp_width array, not reset.
- Sample k of a frame (k = 0..N-1) is written to mem[bitrev(k)], where bitrev reverses the addr_width bits of k.
- States:
  - IDLE: busy=0, frame_ready=0. On sample_valid & frame_start, write the sample to mem[0], set fill_count=1, and go to FILL. sample_valid without frame_start is dropped silently.
  - FILL: busy=1. Each sample_valid writes mem[bitrev(fill_count)] and increments fill_count. When the accepted sample is the N-th (fill_count was N-1), go to READY with fill_count=N.
  - READY: frame_ready=1, busy=0. On rd_en, rd_data ← mem[rd_addr] at the next edge. On frame_release, go to IDLE and set fill_count=0.
- frame_start & sample_valid during FILL (resync):
  - Abandon the partial frame.
  - Write the sample to mem[0] and set fill_count=1.
  - Stay in FILL and set overrun.
- sample_valid in READY without frame_release: the sample is dropped and overrun is set.
- frame_release & frame_start & sample_valid in the same READY cycle:
  - Go directly to FILL.
  - Write the sample to mem[0] and set fill_count=1.
  - No overrun.
- frame_release & sample_valid without frame_start in READY: go to IDLE, drop the sample, no overrun.
- frame_release outside READY: ignored.
- rd_en outside READY: ignored; rd_data holds its value.
- overrun: cleared only by rst.
- Reset (any state, including mid-FILL): state=IDLE, fill_count=0, frame_ready=0, busy=0, overrun=0, rd_data=0. Memory is unchanged. Samples present on the reset cycle are not written.

## Timing
- A write occurs on the edge where sample_valid is sampled high. Back-to-back samples on every cycle are supported. Gaps of any length are allowed within a frame.
- frame_ready rises on the edge that accepts sample N, i.e. visible the cycle after the N-th sample is presented. Minimum frame time is N cycles from the first sample to frame_ready.
- Read latency is 1 cycle: rd_addr presented at cycle t gives rd_data valid at t+1. Reads are allowed every cycle.
- A read in the first READY cycle returns the final written sample correctly (write completes before the read edge).
- frame_release takes effect on the next edge: frame_ready falls the cycle after release.
- fill_count and busy update on the same edges as state.

## Test plan
(N=8, addr_width=3 unless noted.)
- Reset, then frame_start on sample 0 and values 0..7 on consecutive cycles -> frame_ready=1 the cycle after value 7; reading addr 0..7 gives 0,4,2,6,1,5,3,7, each 1 cycle after rd_en.
- Same frame with sample_valid low every other cycle -> frame_ready after the 8th valid sample; fill_count steps 1..8; same read-back.
- frame_start re-asserted at sample 5, then 8 further samples 100..107 -> overrun=1; frame holds 100..107 in bit-reversed order.
- In READY, present a sample without release -> overrun=1, memory unchanged. Then frame_release together with frame_start+200 -> state FILL, fill_count=1, mem[0]=200, frame_ready=0 next cycle.
- rst asserted asynchronously mid-FILL at fill_count=3 -> outputs drop immediately: frame_ready=0, busy=0, fill_count=0, overrun=0. A new full frame then completes normally.
- N=1024: 1024 back-to-back samples valued k -> rd_addr 1 returns 512, rd_addr 1023 returns 1023.

Source files
------------

// File: rtl/fft_frame_receiver.sv
// Frame receiver between the DFT sample buffer and the FFT engine.
// Collects N samples per frame into local memory at bit-reversed addresses,
// then holds the frame for random-access reads until the FFT core releases it.
module fft_frame_receiver #(
   parameter int N          = 1024,
   parameter int fp_width   = 32,
   parameter int addr_width = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_start,
   input  logic                  sample_valid,
   input  logic [fp_width-1:0]   data_in,
   output logic                  frame_ready,
   output logic                  busy,
   output logic [addr_width:0]   fill_count,
   input  logic                  rd_en,
   input  logic [addr_width-1:0] rd_addr,
   output logic [fp_width-1:0]   rd_data,
   input  logic                  frame_release,
   output logic                  overrun
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      READY = 2'd2
   } state_t;

   localparam logic [addr_width:0] LAST_IDX = (addr_width+1)'(N - 1);
   localparam logic [addr_width:0] FULL_CNT = (addr_width+1)'(N);
   localparam logic [addr_width:0] ONE_CNT  = (addr_width+1)'(1);

   state_t                state;
   state_t                state_nxt;
   logic [addr_width:0]   fill_nxt;
   logic                  ovr_nxt;
   logic                  wr_en;
   logic                  mem_we;
   logic [addr_width-1:0] wr_addr;
   logic [fp_width-1:0]   mem [N];

   // Reverse the bit order of a sample index to get its storage address.
   function automatic logic [addr_width-1:0] bitrev(input logic [addr_width-1:0] k);
      logic [addr_width-1:0] r;
      for (int i = 0; i < addr_width; i++) begin
         r[i] = k[addr_width-1-i];
      end
      return r;
   endfunction

   // Next-state, fill counter, overrun and write-port decode.
   always_comb begin
      state_nxt = state;
      fill_nxt  = fill_count;
      ovr_nxt   = overrun;
      wr_en     = 1'b0;
      wr_addr   = '0;
      case (state)
         IDLE: begin
            if (sample_valid && frame_start) begin
               wr_en     = 1'b1;
               fill_nxt  = ONE_CNT;
               state_nxt = FILL;
            end
         end
         FILL: begin
            if (sample_valid && frame_start) begin
               // Resync: abandon the partial frame and restart at sample 0.
               wr_en    = 1'b1;
               fill_nxt = ONE_CNT;
               ovr_nxt  = 1'b1;
            end else if (sample_valid) begin
               wr_en   = 1'b1;
               wr_addr = bitrev(fill_count[addr_width-1:0]);
               if (fill_count == LAST_IDX) begin
                  fill_nxt  = FULL_CNT;
                  state_nxt = READY;
               end else begin
                  fill_nxt = fill_count + ONE_CNT;
               end
            end
         end
         READY: begin
            if (frame_release) begin
               if (sample_valid && frame_start) begin
                  wr_en     = 1'b1;
                  fill_nxt  = ONE_CNT;
                  state_nxt = FILL;
               end else begin
                  fill_nxt  = '0;
                  state_nxt = IDLE;
               end
            end else if (sample_valid) begin
               ovr_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            fill_nxt  = '0;
         end
      endcase
   end

   // A sample present while reset is asserted must not reach memory.
   assign mem_we = wr_en & ~rst;

   // Control registers: state, fill counter and sticky overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         fill_count <= '0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_nxt;
         fill_count <= fill_nxt;
         overrun    <= ovr_nxt;
      end
   end

   // Sample storage write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_addr] <= data_in;
      end
   end

   // Registered read port, live only while a complete frame is held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (state == READY && rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

   assign busy        = (state == FILL);
   assign frame_ready = (state == READY);

endmodule
